// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - forwarding selects and FSM encoding shared by the hazard controller
package hazard_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef enum logic {
    IDLE       = 1'b0,
    LOAD_STALL = 1'b1
  } hz_state_t;

endpackage

// File: rtl/forwarding_unit.sv
// rtl/forwarding_unit.sv - EX operand bypass select for one source register
module forwarding_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  output logic [1:0]            fwd_sel
);

  // MEM holds the younger result, so it takes priority over WB
  always_comb begin
    fwd_sel = FWD_NONE;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs)) begin
      fwd_sel = FWD_MEM;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs)) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - load-use stall, memory freeze, branch flush and forwarding control
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W        = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int PERF_W            = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  input  logic                  branch_taken,
  input  logic                  mem_req,
  input  logic                  dmem_ready,
  output logic                  pc_write_en,
  output logic                  if_id_write_en,
  output logic                  id_ex_bubble,
  output logic                  id_ex_write_en,
  output logic                  ex_mem_write_en,
  output logic                  mem_wb_write_en,
  output logic                  if_id_flush,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [PERF_W-1:0]     stall_cycles
);

  localparam int                 CNT_W    = $clog2(LOAD_STALL_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [PERF_W-1:0]  PERF_MAX = '1;

  hz_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             freeze, hz;
  logic [1:0]       fwd_a_raw, fwd_b_raw;

  assign freeze = mem_req & ~dmem_ready;
  assign hz     = ex_mem_read && (ex_rd != '0) &&
                  ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

  forwarding_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .ex_rs         (ex_rs1),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .fwd_sel       (fwd_a_raw)
  );

  forwarding_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .ex_rs         (ex_rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .fwd_sel       (fwd_b_raw)
  );

  assign fwd_a = rst ? FWD_NONE : fwd_a_raw;
  assign fwd_b = rst ? FWD_NONE : fwd_b_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Priority: reset, then freeze, then branch flush, then load-use stall
  always_comb begin
    state_n         = state;
    cnt_n           = cnt;
    pc_write_en     = 1'b1;
    if_id_write_en  = 1'b1;
    id_ex_bubble    = 1'b0;
    id_ex_write_en  = 1'b1;
    ex_mem_write_en = 1'b1;
    mem_wb_write_en = 1'b1;
    if_id_flush     = 1'b0;
    if (rst) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (freeze) begin
      pc_write_en     = 1'b0;
      if_id_write_en  = 1'b0;
      id_ex_write_en  = 1'b0;
      ex_mem_write_en = 1'b0;
      mem_wb_write_en = 1'b0;
    end else if (branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      state_n      = IDLE;
      cnt_n        = '0;
    end else begin
      case (state)
        IDLE: begin
          if (hz) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_bubble   = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              cnt_n   = CNT_LOAD;
              state_n = LOAD_STALL;
            end
          end
        end
        LOAD_STALL: begin
          pc_write_en    = 1'b0;
          if_id_write_en = 1'b0;
          id_ex_bubble   = 1'b1;
          cnt_n          = cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state_n = IDLE;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (!pc_write_en && (stall_cycles != PERF_MAX)) begin
      stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - scoreboard bench driving a 1-cycle and a 3-cycle controller in parallel
module tb_hazard_ctrl_unit;

  localparam logic [6:0] RUN = 7'b1101110;
  localparam logic [6:0] STL = 7'b0011110;
  localparam logic [6:0] FRZ = 7'b0000000;
  localparam logic [6:0] FLS = 7'b1111111;

  typedef struct packed {
    logic [6:0]  ca;
    logic [15:0] sa;
    logic [6:0]  cb;
    logic [15:0] sb;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        chk;
    int          tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, mem_reg_write, wb_reg_write;
  logic branch_taken, mem_req, dmem_ready;

  logic a_pc, a_ifid, a_bub, a_idex, a_exmem, a_memwb, a_flush;
  logic b_pc, b_ifid, b_bub, b_idex, b_exmem, b_memwb, b_flush;
  logic [1:0]  a_fa, a_fb, b_fa, b_fb;
  logic [15:0] a_sc;
  logic [3:0]  b_sc;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   tag    = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(1), .PERF_W(16)) dut_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .branch_taken(branch_taken), .mem_req(mem_req),
    .dmem_ready(dmem_ready), .pc_write_en(a_pc), .if_id_write_en(a_ifid),
    .id_ex_bubble(a_bub), .id_ex_write_en(a_idex), .ex_mem_write_en(a_exmem),
    .mem_wb_write_en(a_memwb), .if_id_flush(a_flush), .fwd_a(a_fa), .fwd_b(a_fb),
    .stall_cycles(a_sc)
  );

  hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3), .PERF_W(4)) dut_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .branch_taken(branch_taken), .mem_req(mem_req),
    .dmem_ready(dmem_ready), .pc_write_en(b_pc), .if_id_write_en(b_ifid),
    .id_ex_bubble(b_bub), .id_ex_write_en(b_idex), .ex_mem_write_en(b_exmem),
    .mem_wb_write_en(b_memwb), .if_id_flush(b_flush), .fwd_a(b_fa), .fwd_b(b_fb),
    .stall_cycles(b_sc)
  );

  task automatic clr();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0; ex_rs1 = '0; ex_rs2 = '0;
    mem_rd = '0; wb_rd = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_mem_read = 1'b0; mem_reg_write = 1'b0; wb_reg_write = 1'b0;
    branch_taken = 1'b0; mem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic set_hz();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
  endtask

  task automatic cyc(input logic [6:0] ca, input int sa, input logic [6:0] cb, input int sb,
                     input logic [1:0] fa = 2'b00, input logic [1:0] fb = 2'b00,
                     input logic chk = 1'b1);
    exp_t e;
    e.ca = ca; e.sa = 16'(sa); e.cb = cb; e.sb = 16'(sb);
    e.fa = fa; e.fb = fb; e.chk = chk; e.tag = tag;
    tag++;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are combinational, so each pushed step is checked mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({a_pc, a_ifid, a_bub, a_idex, a_exmem, a_memwb, a_flush, a_fa, a_fb} !== {e.ca, e.fa, e.fb}) begin
          errors++;
          $display("FAIL step%0d dutA ctl/fwd got %b_%b_%b want %b_%b_%b", e.tag,
                   {a_pc, a_ifid, a_bub, a_idex, a_exmem, a_memwb, a_flush}, a_fa, a_fb, e.ca, e.fa, e.fb);
        end
        checks++;
        if ({b_pc, b_ifid, b_bub, b_idex, b_exmem, b_memwb, b_flush, b_fa, b_fb} !== {e.cb, e.fa, e.fb}) begin
          errors++;
          $display("FAIL step%0d dutB ctl/fwd got %b_%b_%b want %b_%b_%b", e.tag,
                   {b_pc, b_ifid, b_bub, b_idex, b_exmem, b_memwb, b_flush}, b_fa, b_fb, e.cb, e.fa, e.fb);
        end
        if (e.chk) begin
          checks++;
          if (a_sc !== e.sa) begin
            errors++;
            $display("FAIL step%0d dutA stall_cycles got %0d want %0d", e.tag, a_sc, e.sa);
          end
          checks++;
          if ({12'd0, b_sc} !== e.sb) begin
            errors++;
            $display("FAIL step%0d dutB stall_cycles got %0d want %0d", e.tag, b_sc, e.sb);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    clr();
    @(posedge clk);
    #1;
    // reset forces defaults even with a hazard and a forward pending
    set_hz(); mem_rd = 5'd7; mem_reg_write = 1'b1; ex_rs1 = 5'd7;
    cyc(RUN, 0, RUN, 0);
    rst = 1'b0; clr(); cyc(RUN, 0, RUN, 0);

    // basic load-use: 1 bubble on A, 3 on B
    set_hz(); cyc(STL, 0, STL, 0);
    clr(); cyc(RUN, 1, STL, 1);
    cyc(RUN, 1, STL, 2);
    cyc(RUN, 1, RUN, 3);

    // freeze for 2 cycles in the middle of B's stall
    set_hz(); cyc(STL, 1, STL, 3);
    clr(); mem_req = 1'b1; cyc(FRZ, 2, FRZ, 4);
    cyc(FRZ, 3, FRZ, 5);
    dmem_ready = 1'b1; cyc(RUN, 4, STL, 6);
    clr(); cyc(RUN, 4, STL, 7);
    cyc(RUN, 4, RUN, 8);

    // freeze beats a simultaneous hazard; hazard re-evaluated afterwards
    set_hz(); mem_req = 1'b1; cyc(FRZ, 4, FRZ, 8);
    dmem_ready = 1'b1; cyc(STL, 5, STL, 9);
    clr(); cyc(RUN, 6, STL, 10);
    cyc(RUN, 6, STL, 11);
    cyc(RUN, 6, RUN, 12);
    rst = 1'b1; cyc(RUN, 0, RUN, 0, 2'b00, 2'b00, 1'b0);
    rst = 1'b0; cyc(RUN, 0, RUN, 0);

    // x0, unused source and non-load never stall; rs2 match does
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1; cyc(RUN, 0, RUN, 0);
    ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b0; cyc(RUN, 0, RUN, 0);
    id_rs1 = 5'd5; ex_mem_read = 1'b0; cyc(RUN, 0, RUN, 0);
    clr(); ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1; cyc(STL, 0, STL, 0);
    clr(); cyc(RUN, 1, STL, 1);
    cyc(RUN, 1, STL, 2);
    cyc(RUN, 1, RUN, 3);

    // branch flush: suppresses new stall, aborts B's stall, loses to freeze
    set_hz(); branch_taken = 1'b1; cyc(FLS, 1, FLS, 3);
    clr(); cyc(RUN, 1, RUN, 3);
    set_hz(); cyc(STL, 1, STL, 3);
    clr(); branch_taken = 1'b1; cyc(FLS, 2, FLS, 4);
    clr(); cyc(RUN, 2, RUN, 4);
    branch_taken = 1'b1; mem_req = 1'b1; cyc(FRZ, 2, FRZ, 4);
    clr(); cyc(RUN, 3, RUN, 5);

    // forwarding
    mem_rd = 5'd7; mem_reg_write = 1'b1; wb_rd = 5'd7; wb_reg_write = 1'b1; ex_rs1 = 5'd7;
    cyc(RUN, 3, RUN, 5, 2'b10, 2'b00);
    mem_reg_write = 1'b0; cyc(RUN, 3, RUN, 5, 2'b01, 2'b00);
    ex_rs2 = 5'd7; wb_rd = 5'd0; cyc(RUN, 3, RUN, 5, 2'b00, 2'b00);
    mem_rd = 5'd0; mem_reg_write = 1'b1; ex_rs1 = 5'd0; wb_rd = 5'd3; ex_rs2 = 5'd3;
    cyc(RUN, 3, RUN, 5, 2'b00, 2'b01);
    mem_rd = 5'd3; mem_req = 1'b1; cyc(FRZ, 3, FRZ, 5, 2'b00, 2'b10);
    clr(); cyc(RUN, 4, RUN, 6);

    // reset in the middle of B's stall (cnt=2)
    set_hz(); cyc(STL, 4, STL, 6);
    clr(); rst = 1'b1; cyc(RUN, 0, RUN, 0, 2'b00, 2'b00, 1'b0);
    rst = 1'b0; cyc(RUN, 0, RUN, 0);
    cyc(RUN, 0, RUN, 0);

    // continuous hazard: B's 4-bit counter saturates at 15
    set_hz();
    for (int i = 0; i < 21; i++) cyc(STL, i, STL, (i > 15) ? 15 : i);
    clr(); cyc(RUN, 21, RUN, 15);
    cyc(RUN, 21, RUN, 15);

    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Parametrised hazard controller for the 5-stage RV32I pipeline. It replaces the single-cycle load-use stall detector. The block generates:
- load-use stalls lasting a configurable number of cycles, tracked by a down-counter;
- a full-pipeline freeze while a multi-cycle data-memory access is outstanding;
- IF/ID and ID/EX flushes on a taken branch;
- EX-stage forwarding selects;
- a saturating stall-cycle performance counter.

It sits beside the pipeline registers and drives their write-enable and flush inputs.

## Interface
Parameters:
- REG_ADDR_W, 5, register-index width.
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard; legal range 1..3.
- PERF_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1  the ID instruction actually reads that source.
- ex_rd  in  REG_ADDR_W  destination register of the instruction in EX.
- ex_mem_read  in  1  the EX instruction is a load.
- ex_rs1, ex_rs2  in  REG_ADDR_W  sources of the EX instruction, used for forwarding.
- mem_rd, mem_reg_write  in  REG_ADDR_W/1  destination and write flag for MEM.
- wb_rd, wb_reg_write  in  REG_ADDR_W/1  destination and write flag for WB.
- branch_taken  in  1  branch or jump resolved taken in EX.
- mem_req  in  1  the MEM stage has an active data-memory access.
- dmem_ready  in  1  the data memory completes the access this cycle.
- pc_write_en, if_id_write_en  out  1  hold PC and IF/ID when 0.
- id_ex_bubble  out  1  load a NOP into ID/EX.
- id_ex_write_en, ex_mem_write_en, mem_wb_write_en  out  1  freeze controls.
- if_id_flush  out  1  load a NOP into IF/ID.
- fwd_a, fwd_b  out  2  EX operand select.
- stall_cycles  out  PERF_W  count of cycles in which pc_write_en was 0.

## Operation
- Freeze: `freeze = mem_req & ~dmem_ready`.
  - While freeze is 1, all write enables are 0, all bubble and flush outputs are 0, and the FSM and counter hold.
  - Freeze has top priority.
- FSM states: IDLE, LOAD_STALL.
- Hazard condition, `hz`: `ex_mem_read & ex_rd≠0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd))`.
- IDLE behaviour:
  - If `hz & ~branch_taken & ~freeze`: assert stall (pc_write_en=0, if_id_write_en=0, id_ex_bubble=1) in the same cycle. If LOAD_STALL_CYCLES>1, load `cnt = LOAD_STALL_CYCLES-1` and go to LOAD_STALL.
- LOAD_STALL behaviour:
  - Stall outputs stay asserted.
  - cnt decrements on each unfrozen cycle.
  - When `cnt==1` on an unfrozen edge, go to IDLE.
- Branch flush:
  - `branch_taken & ~freeze` sets `if_id_flush=1` and `id_ex_bubble=1`; pc_write_en stays 1 so the redirect is taken.
  - A branch suppresses a simultaneous new load-use stall.
  - A branch cannot occur in LOAD_STALL, because EX holds a bubble. If branch_taken is nevertheless asserted there, the flush wins and the FSM returns to IDLE.
- Forwarding (combinational, independent of stall and freeze). For fwd_a, using ex_rs1 (fwd_b is identical with ex_rs2):
  - FWD_MEM=2'b10 if `mem_reg_write & mem_rd≠0 & mem_rd==ex_rs1`;
  - otherwise FWD_WB=2'b01 if `wb_reg_write & wb_rd≠0 & wb_rd==ex_rs1`;
  - otherwise FWD_NONE=2'b00.
  - MEM has priority over WB.
- Performance counter:
  - stall_cycles increments on every edge where pc_write_en==0 and rst==0.
  - It saturates at 2^PERF_W−1.
- Register x0 never causes a hazard or a forward.

## Timing
- Stall, flush and freeze outputs are combinational from the inputs and the registered state. Their latency is 0 cycles from the hazard condition.
- A load-use hazard produces exactly LOAD_STALL_CYCLES consecutive unfrozen cycles with pc_write_en=0, plus any frozen cycles inserted in between.
- Reset values, applied at the first rising edge with rst=1 and forced on the outputs while rst=1:
  - state=IDLE, cnt=0, stall_cycles=0;
  - all write enables 1, id_ex_bubble=0, if_id_flush=0, fwd_a=fwd_b=00.
- Reset mid-stall aborts the stall: state=IDLE and cnt=0 on the next edge.
- freeze and hz in the same cycle: freeze wins. The hazard is re-evaluated after dmem_ready, because the pipeline has not moved.

## Structure
- Package `hazard_pkg`: FWD_NONE, FWD_WB, FWD_MEM constants and the state encoding (IDLE=1'b0, LOAD_STALL=1'b1).
- Sub-module `forwarding_unit`: purely combinational, instantiated once per operand (two instances).
- The top level holds the FSM, cnt of width clog2(LOAD_STALL_CYCLES+1), the freeze/priority logic and the perf counter.

## Test plan
- LOAD_STALL_CYCLES=1: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 → exactly one cycle with pc_write_en=0 and id_ex_bubble=1; stall_cycles=1.
- LOAD_STALL_CYCLES=3, same hazard → three consecutive stall cycles. With mem_req=1 and dmem_ready=0 for 2 cycles mid-stall, all enables are 0 for those cycles, cnt holds, and the total stall is 5 cycles.
- ex_rd=0 with matching id_rs1=0, or id_uses_rs2=0 with id_rs2==ex_rd → no stall.
- branch_taken=1 together with a load-use hazard → if_id_flush=1, id_ex_bubble=1, pc_write_en=1, FSM stays IDLE.
- mem_rd=wb_rd=7, both write, ex_rs1=7 → fwd_a=10. With mem_reg_write=0 → fwd_a=01. With ex_rs2=7 and wb_rd=0 → fwd_b=00 (only WB write asserted).
- rst=1 during LOAD_STALL with cnt=2 → next cycle IDLE, outputs at reset values, stall_cycles=0. PERF_W=4 with 20 forced stall cycles → stall_cycles saturates at 15.
